// File: rtl/alu_issue_stage_if.sv
// Handshake bundles for the ALU issue stage: issue side, ALU side, writeback.
interface issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic [4:0]  rd_addr;

    modport master (
        output instr_valid, opcode, rs_data, rt_data, imm16, rd_addr,
        input  instr_ready
    );
    modport slave (
        input  instr_valid, opcode, rs_data, rt_data, imm16, rd_addr,
        output instr_ready
    );
endinterface

interface alu_if;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic        alu_add_sub;
    logic [1:0]  alu_logicfn;
    logic [1:0]  alu_fnclass;
    logic [31:0] alu_result;
    logic        alu_overflow;

    modport master (
        output alu_x, alu_y, alu_add_sub, alu_logicfn, alu_fnclass,
        input  alu_result, alu_overflow
    );
    modport slave (
        input  alu_x, alu_y, alu_add_sub, alu_logicfn, alu_fnclass,
        output alu_result, alu_overflow
    );
endinterface

interface wb_if;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic        wb_ovf;
    logic        wb_illegal;

    modport master (
        output wb_valid, wb_data, wb_addr, wb_we, wb_ovf, wb_illegal,
        input  wb_ready
    );
    modport slave (
        input  wb_valid, wb_data, wb_addr, wb_we, wb_ovf, wb_illegal,
        output wb_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction, drives an external ALU for one
// cycle, then holds the writeback result until the consumer accepts it.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    issue_if.slave      issue,
    alu_if.master       alu,
    wb_if.master        wb,
    output logic [15:0] retired_cnt,
    output logic [15:0] ovf_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] FN_LUI   = 2'b00;
    localparam logic [1:0] FN_SLT   = 2'b01;
    localparam logic [1:0] FN_ARITH = 2'b10;
    localparam logic [1:0] FN_LOGIC = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        add_sub_q, add_sub_d;
    logic [1:0]  logicfn_q, logicfn_d;
    logic [1:0]  fnclass_q, fnclass_d;
    logic [4:0]  rd_q, rd_d;
    logic        ill_q, ill_d;
    logic        ovf_en_q, ovf_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_ovf_q, wb_ovf_d;
    logic        wb_ill_q, wb_ill_d;
    logic [15:0] ret_q, ret_d;
    logic [15:0] ovc_q, ovc_d;

    logic [31:0] dec_x;
    logic [31:0] dec_y;
    logic        dec_add_sub;
    logic [1:0]  dec_logicfn;
    logic [1:0]  dec_fnclass;
    logic        dec_ill;
    logic        dec_ovf_en;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        ovf_now;

    assign sext = {{16{issue.imm16[15]}}, issue.imm16};
    assign zext = {16'h0000, issue.imm16};

    always_comb begin
        dec_x       = issue.rs_data;
        dec_y       = issue.rt_data;
        dec_add_sub = 1'b0;
        dec_logicfn = 2'b00;
        dec_fnclass = FN_ARITH;
        dec_ill     = 1'b0;
        dec_ovf_en  = 1'b0;
        case (issue.opcode)
            4'd0: dec_ovf_en = 1'b1;
            4'd1: begin
                dec_add_sub = 1'b1;
                dec_ovf_en  = 1'b1;
            end
            4'd2, 4'd3, 4'd4, 4'd5: begin
                dec_fnclass = FN_LOGIC;
                dec_logicfn = 2'(issue.opcode - 4'd2);
            end
            4'd6: begin
                dec_fnclass = FN_SLT;
                dec_add_sub = 1'b1;
            end
            4'd7: begin
                dec_y      = sext;
                dec_ovf_en = 1'b1;
            end
            4'd8, 4'd9, 4'd10: begin
                dec_y       = zext;
                dec_fnclass = FN_LOGIC;
                dec_logicfn = 2'(issue.opcode - 4'd8);
            end
            4'd11: begin
                dec_y       = sext;
                dec_fnclass = FN_SLT;
                dec_add_sub = 1'b1;
            end
            4'd12: begin
                dec_x       = 32'h0;
                dec_y       = zext;
                dec_fnclass = FN_LUI;
            end
            default: begin
                // Illegal ops present an all-zero ALU request
                dec_x       = 32'h0;
                dec_y       = 32'h0;
                dec_fnclass = FN_LUI;
                dec_ill     = 1'b1;
            end
        endcase
    end

    assign ovf_now = ovf_en_q & alu.alu_overflow;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        add_sub_d = add_sub_q;
        logicfn_d = logicfn_q;
        fnclass_d = fnclass_q;
        rd_d      = rd_q;
        ill_d     = ill_q;
        ovf_en_d  = ovf_en_q;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        wb_we_d   = wb_we_q;
        wb_ovf_d  = wb_ovf_q;
        wb_ill_d  = wb_ill_q;
        ret_d     = ret_q;
        ovc_d     = ovc_q;
        unique case (state_q)
            IDLE: begin
                if (issue.instr_valid) begin
                    x_d       = dec_x;
                    y_d       = dec_y;
                    add_sub_d = dec_add_sub;
                    logicfn_d = dec_logicfn;
                    fnclass_d = dec_fnclass;
                    rd_d      = issue.rd_addr;
                    ill_d     = dec_ill;
                    ovf_en_d  = dec_ovf_en;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                wb_data_d = ill_q ? 32'h0 : alu.alu_result;
                wb_ovf_d  = ovf_now;
                wb_addr_d = rd_q;
                wb_ill_d  = ill_q;
                wb_we_d   = !ill_q && !ovf_now && (rd_q != 5'd0);
                x_d       = 32'h0;
                y_d       = 32'h0;
                add_sub_d = 1'b0;
                logicfn_d = 2'b00;
                fnclass_d = 2'b00;
                state_d   = WB;
            end
            WB: begin
                if (wb.wb_ready) begin
                    ret_d     = ret_q + {15'h0, !wb_ill_q};
                    ovc_d     = ovc_q + {15'h0, wb_ovf_q};
                    wb_data_d = 32'h0;
                    wb_addr_d = 5'd0;
                    wb_we_d   = 1'b0;
                    wb_ovf_d  = 1'b0;
                    wb_ill_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= 32'h0;
            y_q       <= 32'h0;
            add_sub_q <= 1'b0;
            logicfn_q <= 2'b00;
            fnclass_q <= 2'b00;
            rd_q      <= 5'd0;
            ill_q     <= 1'b0;
            ovf_en_q  <= 1'b0;
            wb_data_q <= 32'h0;
            wb_addr_q <= 5'd0;
            wb_we_q   <= 1'b0;
            wb_ovf_q  <= 1'b0;
            wb_ill_q  <= 1'b0;
            ret_q     <= 16'h0;
            ovc_q     <= 16'h0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            add_sub_q <= add_sub_d;
            logicfn_q <= logicfn_d;
            fnclass_q <= fnclass_d;
            rd_q      <= rd_d;
            ill_q     <= ill_d;
            ovf_en_q  <= ovf_en_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            wb_we_q   <= wb_we_d;
            wb_ovf_q  <= wb_ovf_d;
            wb_ill_q  <= wb_ill_d;
            ret_q     <= ret_d;
            ovc_q     <= ovc_d;
        end
    end

    assign issue.instr_ready = (state_q == IDLE) && rst_n;

    assign alu.alu_x       = x_q;
    assign alu.alu_y       = y_q;
    assign alu.alu_add_sub = add_sub_q;
    assign alu.alu_logicfn = logicfn_q;
    assign alu.alu_fnclass = fnclass_q;

    assign wb.wb_valid   = (state_q == WB);
    assign wb.wb_data    = wb_data_q;
    assign wb.wb_addr    = wb_addr_q;
    assign wb.wb_we      = wb_we_q;
    assign wb.wb_ovf     = wb_ovf_q;
    assign wb.wb_illegal = wb_ill_q;

    assign retired_cnt = ret_q;
    assign ovf_cnt     = ovc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with an ALU model and a reference
// model of the instruction semantics.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] retired_cnt;
    logic [15:0] ovf_cnt;

    always #5 clk = ~clk;

    issue_if iss ();
    alu_if   alu ();
    wb_if    wb ();

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (iss),
        .alu         (alu),
        .wb          (wb),
        .retired_cnt (retired_cnt),
        .ovf_cnt     (ovf_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        we;
        logic        ill;
        logic [4:0]  addr;
        logic [31:0] y;
        logic        add_sub;
        logic [1:0]  fncls;
        logic [1:0]  lfn;
    } exp_t;

    exp_t        q[$];
    int          passed = 0;
    int          total = 0;
    logic [15:0] exp_ret = 16'h0;
    logic [15:0] exp_ovf = 16'h0;
    logic        pend = 1'b0;
    logic        junk_ovf = 1'b0;
    logic        tb_ill = 1'b0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    endtask

    // Environment ALU; junk overflow on non-arith classes exercises masking
    function automatic logic [32:0] alu_fn(logic [31:0] x, logic [31:0] y,
                                           logic as, logic [1:0] lf,
                                           logic [1:0] fc, logic jo);
        longint a = longint'($signed(x));
        longint b = longint'($signed(y));
        longint s = as ? a - b : a + b;
        logic o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        logic [31:0] r;
        case (fc)
            2'b00: r = y << 16;
            2'b01: r = (a < b) ? 32'd1 : 32'd0;
            2'b10: r = s[31:0];
            default: case (lf)
                2'b00: r = x & y;
                2'b01: r = x | y;
                2'b10: r = x ^ y;
                default: r = ~(x | y);
            endcase
        endcase
        if (fc != 2'b10) o = jo;
        return {o, r};
    endfunction

    logic [32:0] alu_out;
    assign alu_out = alu_fn(alu.alu_x, alu.alu_y, alu.alu_add_sub,
                            alu.alu_logicfn, alu.alu_fnclass, junk_ovf);
    assign alu.alu_overflow = alu_out[32];
    assign alu.alu_result   = tb_ill ? 32'hDEADBEEF : alu_out[31:0];

    function automatic exp_t ref_model(int op, logic [31:0] rs,
                                       logic [31:0] rt, logic [15:0] imm,
                                       logic [4:0] rd);
        exp_t e;
        longint a = longint'($signed(rs));
        longint b = longint'($signed(rt));
        longint si = longint'($signed(imm));
        logic [31:0] zi = {16'h0, imm};
        longint r = 0;
        logic ar = 1'b0;
        e = '{default: '0};
        e.addr = rd;
        case (op)
            0: begin r = a + b; ar = 1; e.fncls = 2; e.y = rt; end
            1: begin r = a - b; ar = 1; e.fncls = 2; e.y = rt; e.add_sub = 1; end
            2: begin e.data = rs & rt; e.fncls = 3; e.lfn = 0; e.y = rt; end
            3: begin e.data = rs | rt; e.fncls = 3; e.lfn = 1; e.y = rt; end
            4: begin e.data = rs ^ rt; e.fncls = 3; e.lfn = 2; e.y = rt; end
            5: begin e.data = ~(rs | rt); e.fncls = 3; e.lfn = 3; e.y = rt; end
            6: begin e.data = {31'h0, a < b}; e.fncls = 1; e.y = rt; e.add_sub = 1; end
            7: begin r = a + si; ar = 1; e.fncls = 2; e.y = 32'(si); end
            8: begin e.data = rs & zi; e.fncls = 3; e.lfn = 0; e.y = zi; end
            9: begin e.data = rs | zi; e.fncls = 3; e.lfn = 1; e.y = zi; end
            10: begin e.data = rs ^ zi; e.fncls = 3; e.lfn = 2; e.y = zi; end
            11: begin e.data = {31'h0, a < si}; e.fncls = 1; e.y = 32'(si); e.add_sub = 1; end
            12: begin e.data = {imm, 16'h0}; e.fncls = 0; e.y = zi; end
            default: e.ill = 1;
        endcase
        if (ar) begin
            e.data = r[31:0];
            e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end
        e.we = !e.ill && !e.ovf && (rd != 5'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pend) begin
                chk("retired_cnt", {16'h0, retired_cnt}, {16'h0, exp_ret});
                chk("ovf_cnt", {16'h0, ovf_cnt}, {16'h0, exp_ovf});
                pend = 1'b0;
            end
            if (wb.wb_valid && wb.wb_ready) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL wb_unexpected actual=valid expected=none");
                end else begin
                    e = q.pop_front();
                    chk("wb_data", wb.wb_data, e.data);
                    chk("wb_addr", {27'h0, wb.wb_addr}, {27'h0, e.addr});
                    chk("wb_we", {31'h0, wb.wb_we}, {31'h0, e.we});
                    chk("wb_ovf", {31'h0, wb.wb_ovf}, {31'h0, e.ovf});
                    chk("wb_illegal", {31'h0, wb.wb_illegal}, {31'h0, e.ill});
                    if (!e.ill) exp_ret++;
                    if (e.ovf) exp_ovf++;
                    pend = 1'b1;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input int op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm,
                         input logic [4:0] rd, input int delay,
                         input bit junk);
        exp_t e;
        e = ref_model(op, rs, rt, imm, rd);
        iss.opcode = 4'(op);
        iss.rs_data = rs;
        iss.rt_data = rt;
        iss.imm16 = imm;
        iss.rd_addr = rd;
        iss.instr_valid = 1'b1;
        wb.wb_ready = 1'b0;
        tb_ill = e.ill;
        junk_ovf = 1'($urandom);
        @(negedge clk);
        chk("instr_ready_idle", {31'h0, iss.instr_ready}, 32'd1);
        @(posedge clk);
        q.push_back(e);
        #1 iss.instr_valid = 1'b0;
        @(negedge clk);
        chk("wb_valid_exec", {31'h0, wb.wb_valid}, 32'd0);
        if (!e.ill) begin
            chk("alu_y", alu.alu_y, e.y);
            chk("alu_add_sub", {31'h0, alu.alu_add_sub}, {31'h0, e.add_sub});
            chk("alu_fnclass", {30'h0, alu.alu_fnclass}, {30'h0, e.fncls});
            if (e.fncls == 2'b11)
                chk("alu_logicfn", {30'h0, alu.alu_logicfn}, {30'h0, e.lfn});
            if (op <= 6) chk("alu_x", alu.alu_x, rs);
        end
        @(posedge clk);
        #1;
        wb.wb_ready = (delay == 0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wb_valid_stall", {31'h0, wb.wb_valid}, 32'd1);
            chk("instr_ready_stall", {31'h0, iss.instr_ready}, 32'd0);
            chk("wb_data_stable", wb.wb_data, q[0].data);
            chk("wb_we_stable", {31'h0, wb.wb_we}, {31'h0, q[0].we});
            chk("wb_ovf_stable", {31'h0, wb.wb_ovf}, {31'h0, q[0].ovf});
            @(posedge clk);
            #1;
            if (junk && i < delay - 1) begin
                iss.opcode = 4'($urandom_range(0, 12));
                iss.rd_addr = 5'($urandom);
                iss.instr_valid = 1'b1;
            end else begin
                iss.instr_valid = 1'b0;
            end
            if (i == delay - 1) wb.wb_ready = 1'b1;
        end
        @(negedge clk);
        chk("wb_valid_latency", {31'h0, wb.wb_valid}, 32'd1);
        @(posedge clk);
        #1 wb.wb_ready = 1'b0;
        @(negedge clk);
        chk("wb_valid_drop", {31'h0, wb.wb_valid}, 32'd0);
        chk("instr_ready_back", {31'h0, iss.instr_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick(int sel);
        case (sel)
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk_all_zero(input string n);
        chk({n, "_instr_ready"}, {31'h0, iss.instr_ready}, 32'd0);
        chk({n, "_wb_valid"}, {31'h0, wb.wb_valid}, 32'd0);
        chk({n, "_alu_x"}, alu.alu_x, 32'd0);
        chk({n, "_alu_y"}, alu.alu_y, 32'd0);
        chk({n, "_alu_ctl"}, {27'h0, alu.alu_add_sub, alu.alu_logicfn,
                              alu.alu_fnclass}, 32'd0);
        chk({n, "_wb_bus"}, wb.wb_data | {27'h0, wb.wb_addr}, 32'd0);
        chk({n, "_wb_flags"}, {29'h0, wb.wb_we, wb.wb_ovf, wb.wb_illegal},
            32'd0);
        chk({n, "_cnts"}, {retired_cnt, ovf_cnt}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        iss.instr_valid = 1'b0;
        iss.opcode = 4'd0;
        iss.rs_data = 32'h0;
        iss.rt_data = 32'h0;
        iss.imm16 = 16'h0;
        iss.rd_addr = 5'd0;
        wb.wb_ready = 1'b0;
        #3 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wb.wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_wb_valid", {31'h0, wb.wb_valid}, 32'd0);
        chk("idle_cnts", {retired_cnt, ovf_cnt}, 32'd0);
        @(posedge clk);
        #1 wb.wb_ready = 1'b0;

        issue(0, 32'h7FFFFFFF, 32'd1, 16'h0, 5'd3, 0, 0);
        chk("r030_ovf_cnt", {16'h0, ovf_cnt}, 32'd1);
        chk("r030_retired", {16'h0, retired_cnt}, 32'd1);
        issue(7, 32'd5, 32'h0, 16'hFFFE, 5'd7, 1, 0);
        issue(12, 32'h0, 32'h0, 16'h1234, 5'd0, 0, 0);
        issue(14, 32'h1, 32'h2, 16'h3, 5'd9, 2, 0);
        chk("r033_retired", {16'h0, retired_cnt}, 32'd3);
        issue(11, 32'hFFFFFFF0, 32'h0, 16'h0004, 5'd12, 5, 1);

        iss.opcode = 4'd0;
        iss.rs_data = 32'h11;
        iss.rt_data = 32'h22;
        iss.rd_addr = 5'd4;
        iss.instr_valid = 1'b1;
        tb_ill = 1'b0;
        @(posedge clk);
        #1 iss.instr_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        q.delete();
        exp_ret = 16'h0;
        exp_ovf = 16'h0;
        pend = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1, 32'h80000000, 32'd1, 16'h0, 5'd2, 0, 0);
        chk("post_reset_retired", {16'h0, retired_cnt}, 32'd1);

        for (int n = 0; n < 150; n++) begin
            issue($urandom_range(0, 15), pick($urandom_range(0, 7)),
                  pick($urandom_range(0, 7)), 16'($urandom),
                  5'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
        @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        chk("final_retired", {16'h0, retired_cnt}, {16'h0, exp_ret});
        chk("final_ovf", {16'h0, ovf_cnt}, {16'h0, exp_ovf});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
